// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV datapath sequencer: fetch, decode and per-class execution cycles
// for R-type, OP-IMM, load, store and BEQ, with a sticky trap on unknown opcodes.
//
// state  | meaning
// FETCH  | read instruction at PC; load IR and PC+4 when memory answers
// DECODE | compute branch target into ALUOut, dispatch on opcode
// ADDR   | compute load/store effective address
// MEM_RD | load data read, held until mem_ready
// WB_MEM | write memory data register to rd
// MEM_WR | store data write, held until mem_ready
// EXEC_R | register-register ALU operation
// EXEC_I | register-immediate ALU operation
// WB_ALU | write ALUOut to rd
// BRANCH | compare rs1/rs2, take target when equal
// TRAP   | unsupported opcode; parked until reset
module multicycle_control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_src,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_ADDR   = 4'd2,
      S_MEM_RD = 4'd3,
      S_WB_MEM = 4'd4,
      S_MEM_WR = 4'd5,
      S_EXEC_R = 4'd6,
      S_EXEC_I = 4'd7,
      S_WB_ALU = 4'd8,
      S_BRANCH = 4'd9,
      S_TRAP   = 4'd15
   } state_t;

   state_t cur_state, nxt_state;
   logic   illegal_q;
   logic   pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (cur_state == S_DECODE && nxt_state == S_TRAP)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      nxt_state   = cur_state;
      pc_write_s  = 1'b0;
      pc_src      = 1'b0;
      ir_write_s  = 1'b0;
      iord        = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      alu_op      = 2'b00;
      case (cur_state)
         S_FETCH: begin
            mem_read_s = 1'b1;
            alu_src_b  = 2'd1;
            ir_write_s = mem_ready;
            pc_write_s = mem_ready;
            if (mem_ready) nxt_state = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd2;
            case (opcode)
               OPC_LOAD, OPC_STORE: nxt_state = S_ADDR;
               OPC_OP:              nxt_state = S_EXEC_R;
               OPC_OP_IMM:          nxt_state = S_EXEC_I;
               OPC_BRANCH:          nxt_state = S_BRANCH;
               default:             nxt_state = S_TRAP;
            endcase
         end
         S_ADDR: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            nxt_state = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read_s = 1'b1;
            iord       = 1'b1;
            if (mem_ready) nxt_state = S_WB_MEM;
         end
         S_WB_MEM: begin
            reg_write_s = 1'b1;
            mem_to_reg  = 1'b1;
            nxt_state   = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_s = 1'b1;
            iord        = 1'b1;
            if (mem_ready) nxt_state = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 2'd1;
            alu_op    = 2'b10;
            nxt_state = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_op    = 2'b10;
            nxt_state = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_write_s = 1'b1;
            nxt_state   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 2'd1;
            alu_op     = 2'b01;
            pc_src     = 1'b1;
            pc_write_s = zero;
            nxt_state  = S_FETCH;
         end
         S_TRAP:  nxt_state = S_TRAP;
         default: nxt_state = S_FETCH;
      endcase
   end

   // Reset forces state to FETCH, whose request must not leak out while rst_n is low.
   assign pc_write  = pc_write_s  & rst_n;
   assign ir_write  = ir_write_s  & rst_n;
   assign mem_read  = mem_read_s  & rst_n;
   assign mem_write = mem_write_s & rst_n;
   assign reg_write = reg_write_s & rst_n;
   assign illegal   = illegal_q;
   assign state     = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected cycle plans built from
// instruction class and random memory waits, compared every cycle against the DUT.
module tb_multicycle_control_unit;

   logic       clk, rst_n, zero, mem_ready;
   logic [6:0] opcode;
   logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
   logic [1:0] alu_src_a, alu_src_b, alu_op;
   logic       illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;
   bit model_ill = 1'b0;

   typedef struct { int st; bit mr; } cyc_t;
   cyc_t plan[$];

   localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_TRAP = 5;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] observed();
      return {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
              alu_src_a, alu_src_b, alu_op, illegal};
   endfunction

   // Output table per state as listed for the controller.
   function automatic logic [14:0] expected(int st, bit mr, bit z, bit ill);
      logic pcw, pcs, irw, ior, mrd, mwr, rw, m2r;
      logic [1:0] a, b, op;
      {pcw, pcs, irw, ior, mrd, mwr, rw, m2r} = 8'b0;
      a = 2'd0; b = 2'd0; op = 2'd0;
      case (st)
         0:  begin mrd = 1; b = 2'd1; irw = mr; pcw = mr; end
         1:  begin a = 2'd2; b = 2'd2; end
         2:  begin a = 2'd1; b = 2'd2; end
         3:  begin mrd = 1; ior = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; ior = 1; end
         6:  begin a = 2'd1; op = 2'b10; end
         7:  begin a = 2'd1; b = 2'd2; op = 2'b10; end
         8:  begin rw = 1; end
         9:  begin a = 2'd1; op = 2'b01; pcs = 1; pcw = z; end
         default: ;
      endcase
      return {pcw, pcs, irw, ior, mrd, mwr, rw, m2r, a, b, op, ill};
   endfunction

   function automatic logic [14:0] reset_vec();
      return {8'b0, 2'd0, 2'd1, 2'd0, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, {11'b0, state}, 15'd0);
      check({tag, "_outs"}, observed(), reset_vec());
   endtask

   function automatic logic [6:0] opcode_of(int cls);
      logic [6:0] o;
      case (cls)
         C_LOAD:  o = 7'b0000011;
         C_STORE: o = 7'b0100011;
         C_R:     o = 7'b0110011;
         C_I:     o = 7'b0010011;
         C_BEQ:   o = 7'b1100011;
         default: begin
            do o = 7'($urandom);
            while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                   o == 7'b0010011 || o == 7'b1100011);
         end
      endcase
      return o;
   endfunction

   task automatic push(input int st, input bit mr);
      cyc_t c;
      c.st = st; c.mr = mr;
      plan.push_back(c);
   endtask

   // Build the cycle plan: fetch waits, decode, class-specific cycles.
   task automatic run_instr(input int cls, input int wf, input int wm, input bit z,
                            input bit abort_wr, input logic [6:0] opc_force = 7'h00);
      plan.delete();
      for (int i = 0; i < wf; i++) push(0, 1'b0);
      push(0, 1'b1);
      push(1, 1'($urandom));
      case (cls)
         C_LOAD: begin
            push(2, 1'($urandom));
            for (int i = 0; i < wm; i++) push(3, 1'b0);
            push(3, 1'b1);
            push(4, 1'($urandom));
         end
         C_STORE: begin
            push(2, 1'($urandom));
            for (int i = 0; i < wm; i++) push(5, 1'b0);
            push(5, 1'b1);
         end
         C_R:   begin push(6, 1'($urandom)); push(8, 1'($urandom)); end
         C_I:   begin push(7, 1'($urandom)); push(8, 1'($urandom)); end
         C_BEQ: push(9, 1'($urandom));
         default: for (int i = 0; i < 10; i++) push(15, 1'($urandom));
      endcase
      opcode = (opc_force != 7'h00) ? opc_force : opcode_of(cls);
      for (int i = 0; i < plan.size(); i++) begin
         mem_ready = plan[i].mr;
         zero      = z;
         if (plan[i].st == 15) model_ill = 1'b1;
         #1;
         check("state", {11'b0, state}, 15'(plan[i].st));
         check("outs", observed(), expected(plan[i].st, plan[i].mr, z, model_ill));
         if (abort_wr && plan[i].st == 5) begin
            #2 rst_n = 1'b0;
            #1;
            model_ill = 1'b0;
            check_reset("rst_in_memwr");
            @(posedge clk); #1 rst_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; opcode = 7'h00; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset("reset");
      mem_ready = 1'b1; zero = 1'b1;
      #1 check_reset("reset_mr_high");
      rst_n = 1'b1;

      run_instr(C_I, 0, 0, 1'b0, 1'b0);            // addi
      run_instr(C_LOAD, 0, 2, 1'b0, 1'b0);         // lw, 2 MEM_RD waits
      run_instr(C_STORE, 1, 0, 1'b0, 1'b0);        // sw, 1 fetch wait
      run_instr(C_BEQ, 0, 0, 1'b1, 1'b0);          // beq taken
      run_instr(C_BEQ, 0, 0, 1'b0, 1'b0);          // beq not taken
      run_instr(C_R, 0, 0, 1'b0, 1'b0);
      run_instr(C_STORE, 0, 2, 1'b0, 1'b1);        // reset during MEM_WR
      run_instr(C_I, 1, 0, 1'b1, 1'b0);            // restart after reset

      for (int n = 0; n < 60; n++)
         run_instr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom), 1'b0);

      run_instr(C_TRAP, 1, 0, 1'b0, 1'b0, 7'b1111111);
      #2 rst_n = 1'b0;
      #1;
      model_ill = 1'b0;
      check_reset("rst_in_trap");
      @(posedge clk); #1 rst_n = 1'b1;
      run_instr(C_TRAP, 0, 0, 1'b1, 1'b0);         // random unsupported opcode
      #2 rst_n = 1'b0;
      #1;
      model_ill = 1'b0;
      check_reset("rst_in_trap2");
      @(posedge clk); #1 rst_n = 1'b1;
      run_instr(C_LOAD, 0, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style sequencing FSM for the multi-cycle RV datapath. It fetches an instruction, decodes its opcode, and steps the shared ALU, memory port, register file, PC and instruction register through the per-class cycles. The supported classes are R-type, OP-IMM, load, store and BEQ. It sits beside the instruction register. The immediate generation unit's output feeds the ALU B-mux when this block selects it.

## Interface
Parameters:
- none; opcodes fixed: LOAD 7'b0000011, OP_IMM 7'b0010011, STORE 7'b0100011, OP 7'b0110011, BRANCH 7'b1100011

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instruction[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completion strobe; valid in FETCH, MEM_RD, MEM_WR
- pc_write  out  1  PC load enable
- pc_src  out  1  PC input select: 0 = ALU result, 1 = ALUOut register (branch target)
- ir_write  out  1  instruction register load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = memory data register
- alu_src_a  out  2  A select: 0 = PC, 1 = rs1, 2 = old PC
- alu_src_b  out  2  B select: 0 = rs2, 1 = constant 4, 2 = immediate
- alu_op  out  2  ALU operation: 00 = add, 01 = subtract, 10 = decode funct3/funct7
- illegal  out  1  sticky flag: an unsupported opcode was decoded
- state  out  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, ADDR=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, WB_ALU=8, BRANCH=9, TRAP=15.
- Outputs are decoded from `state`. Only the FETCH `ir_write`/`pc_write` and the BRANCH `pc_write` are additionally gated combinationally by an input, as noted below. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=2, alu_src_b=2, alu_op=00, so the branch target is latched into ALUOut. Next state by opcode:
  - LOAD or STORE → ADDR
  - OP → EXEC_R
  - OP_IMM → EXEC_I
  - BRANCH → BRANCH
  - any other value → TRAP
- ADDR: alu_src_a=1, alu_src_b=2, alu_op=00. LOAD → MEM_RD; STORE → MEM_WR.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready=1, then → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready=1, then → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=10 → WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_write=zero → FETCH.
- TRAP: all enables 0, illegal=1. Terminal until reset; mem_ready and opcode are ignored.
- `illegal` is a register: set on the DECODE→TRAP transition, cleared only by reset.

## Timing
- Reset (rst_n=0, asynchronous): state=FETCH, illegal=0.
  - While rst_n=0, every enable (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0. Select outputs take their FETCH values.
  - First fetch request appears in the first cycle after rst_n rises.
- Zero-wait-state latency (mem_ready=1 in every memory state), in cycles per instruction:
  - load: 5
  - store: 4
  - R-type / OP-IMM: 4
  - BEQ: 3
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Request outputs stay asserted and stable throughout the wait.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- opcode is sampled in DECODE and ADDR only. The IR is not rewritten until the next FETCH, so it is stable in both states.
- Reset asserted mid-instruction: the instruction is abandoned and outputs obey the reset rules in the same cycle. No partial reg_write or mem_write is issued after reset is asserted.
- BRANCH with zero=0: pc_write=0, and the PC keeps PC+4 from FETCH.

## Test plan
- Reset then addi (opcode 0010011), mem_ready tied 1 → state sequence 0,1,7,8,0; reg_write=1 only in state 8; illegal=0.
- lw (0000011), mem_ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0 (7 cycles); mem_read and iord held 1 through all three MEM_RD cycles; mem_to_reg=1 in WB_MEM.
- sw (0100011) with 1 fetch wait cycle → sequence 0,0,1,2,5,0; ir_write pulses once, only in the FETCH cycle with mem_ready=1; mem_write=1 only in state 5.
- beq (1100011) with zero=1, then again with zero=0 → pc_write=1 with pc_src=1 in state 9 for the first; pc_write=0 in state 9 for the second; both take 3 cycles.
- Opcode 1111111 → DECODE → TRAP (15); illegal=1 and all enables 0 for 10 cycles regardless of mem_ready. Then pulse rst_n low → state=0, illegal=0 asynchronously.
- rst_n pulsed low during MEM_WR of a store → mem_write drops to 0 in the same cycle; state=0; after release the FETCH sequence restarts.
